// File: rtl/uart_pkg.sv
// Register map, STATUS bit layout and TX frame states for the UART peripheral.
// Shared with the TX peripheral now and an RX block later.
package uart_pkg;

    localparam logic [1:0] UART_OFS_DATA   = 2'd0;
    localparam logic [1:0] UART_OFS_STATUS = 2'd1;
    localparam logic [1:0] UART_OFS_DIV    = 2'd2;

    localparam int UART_ST_FULL   = 0;
    localparam int UART_ST_BUSY   = 1;
    localparam int UART_ST_EMPTY  = 2;
    localparam int UART_ST_PARITY = 3;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    function automatic logic [31:0] status_word(input logic full, input logic busy,
                                                input logic empty, input logic parity);
        logic [31:0] w;
        w                 = '0;
        w[UART_ST_FULL]   = full;
        w[UART_ST_BUSY]   = busy;
        w[UART_ST_EMPTY]  = empty;
        w[UART_ST_PARITY] = parity;
        return w;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with extra-MSB pointers; pop data is valid whenever not empty.
// One-cycle push-to-visible latency; pushes while full and pops while empty are dropped.
module uart_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_dout
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_push_ok;
    logic             w_pop_ok;

    // Flags come only from registered pointers, so a push into a full FIFO waits a cycle even if a pop frees a slot.
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_dout    = r_mem[r_rd_ptr[AW-1:0]];
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_periph.sv
// picorv32-bus UART transmitter (DATA/STATUS/DIV regs, FIFO, 8N1; 8E1 when UART_TX_PARITY_EN is defined).
// mem_ready is a registered single-cycle pulse one cycle after select; DATA writes stall while the FIFO is full.
module uart_tx_periph
    import uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h2000_0000,
    parameter int          FIFO_DEPTH = 16,
    parameter logic [15:0] DIV_RESET  = 16'd867
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic [31:0] mem_rdata,
    output logic        uart_txd
);
`ifdef UART_TX_PARITY_EN
    localparam logic PARITY_PRESENT = 1'b1;
`else
    localparam logic PARITY_PRESENT = 1'b0;
`endif

    logic        w_sel;
    logic        w_is_wr;
    logic        w_push_req;
    logic        w_accept;
    logic        w_push;
    logic        w_pop;
    logic        w_full;
    logic        w_empty;
    logic        w_busy;
    logic        w_bit_end;
    logic [1:0]  w_ofs;
    logic [7:0]  w_fifo_dout;
    logic [31:0] w_rd_word;
    logic        w_unused;

    logic        r_ready;
    logic [31:0] r_rdata;
    logic [15:0] r_div;
    tx_state_t   r_state;
    logic [7:0]  r_shift;
    logic [15:0] r_bit_div;
    logic [15:0] r_cnt;
    logic [2:0]  r_bit_idx;
    logic        r_txd;
`ifdef UART_TX_PARITY_EN
    logic        r_parity;
`endif

    assign w_sel      = mem_valid && (mem_addr[31:4] == BASE_ADDR[31:4]);
    assign w_ofs      = mem_addr[3:2];
    assign w_is_wr    = |mem_wstrb;
    assign w_push_req = w_sel && w_is_wr && (w_ofs == UART_OFS_DATA) && mem_wstrb[0];
    // The !r_ready term blocks a second accept while the core is still dropping mem_valid.
    assign w_accept   = w_sel && !r_ready && !(w_push_req && w_full);
    assign w_push     = w_accept && w_push_req;
    assign w_busy     = (r_state != TX_IDLE) || !w_empty;
    assign w_bit_end  = (r_cnt == r_bit_div);
    assign w_pop      = !w_empty && ((r_state == TX_IDLE) || ((r_state == TX_STOP) && w_bit_end));
    assign w_unused   = &{1'b0, mem_addr[1:0], mem_wdata[31:16], mem_wstrb[3:2]};

    assign mem_ready  = r_ready;
    assign mem_rdata  = r_rdata;
    assign uart_txd   = r_txd;

    always_comb begin
        w_rd_word = '0;
        case (w_ofs)
            UART_OFS_STATUS: w_rd_word = status_word(w_full, w_busy, w_empty, PARITY_PRESENT);
            UART_OFS_DIV:    w_rd_word = {16'h0000, r_div};
            default:         w_rd_word = '0;
        endcase
    end

    uart_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_din   (mem_wdata[7:0]),
        .i_pop   (w_pop),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_dout  (w_fifo_dout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ready <= 1'b0;
            r_rdata <= '0;
            r_div   <= DIV_RESET;
        end else begin
            r_ready <= w_accept;
            r_rdata <= (w_accept && !w_is_wr) ? w_rd_word : 32'h0;
            if (w_accept && w_is_wr && (w_ofs == UART_OFS_DIV)) begin
                if (mem_wstrb[0]) r_div[7:0]  <= mem_wdata[7:0];
                if (mem_wstrb[1]) r_div[15:8] <= mem_wdata[15:8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= TX_IDLE;
            r_txd     <= 1'b1;
            r_shift   <= '0;
            r_bit_div <= '0;
            r_cnt     <= '0;
            r_bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else if (w_pop) begin
            // Loading from IDLE or straight out of STOP; DIV is sampled once per frame here.
            r_state   <= TX_START;
            r_txd     <= 1'b0;
            r_shift   <= w_fifo_dout;
            r_bit_div <= r_div;
            r_cnt     <= '0;
            r_bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
            r_parity  <= ^w_fifo_dout;
`endif
        end else begin
            case (r_state)
                TX_IDLE: begin
                    r_txd <= 1'b1;
                end
                TX_START: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_state <= TX_DATA;
                        r_txd   <= r_shift[0];
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                TX_DATA: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            r_state <= TX_PARITY;
                            r_txd   <= r_parity;
`else
                            r_state <= TX_STOP;
                            r_txd   <= 1'b1;
`endif
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_txd     <= r_shift[1];
                        end
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                TX_PARITY: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_state <= TX_STOP;
                        r_txd   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
`endif
                TX_STOP: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_state <= TX_IDLE;
                        r_txd   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                default: begin
                    r_state <= TX_IDLE;
                    r_txd   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_periph.sv
// Directed bench for uart_tx_periph: register map, frame shape, FIFO stall, back-to-back frames, reset.
// Define UART_TX_PARITY_EN for both bench and RTL to exercise the 11-bit frame.
module tb_uart_tx_periph;

`ifdef UART_TX_PARITY_EN
    localparam int          NB      = 11;
    localparam logic [31:0] ST_IDLE = 32'h0000_000C;
`else
    localparam int          NB      = 10;
    localparam logic [31:0] ST_IDLE = 32'h0000_0004;
`endif
    localparam logic [31:0] A_DATA = 32'h2000_0000;
    localparam logic [31:0] A_STAT = 32'h2000_0004;
    localparam logic [31:0] A_DIV  = 32'h2000_0008;
    localparam logic [31:0] A_RSV  = 32'h2000_000C;

    logic        clk;
    logic        rst;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        uart_txd;

    int checks = 0;
    int errors = 0;

    uart_tx_periph dut (
        .clk       (clk),
        .rst       (rst),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_rdata (mem_rdata),
        .uart_txd  (uart_txd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bit 0 of the result is the start bit.
    function automatic logic [NB-1:0] frame_bits(input logic [7:0] d);
`ifdef UART_TX_PARITY_EN
        return {1'b1, ^d, d, 1'b0};
`else
        return {1'b1, d, 1'b0};
`endif
    endfunction

    // Called just after a negedge; returns just after the negedge on which mem_ready was seen.
    task automatic bus_xfer(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] strb,
                            input int max_wait, output logic [31:0] rdata, output int waited);
        mem_addr  = addr;
        mem_wdata = wdata;
        mem_wstrb = strb;
        mem_valid = 1'b1;
        waited    = 0;
        rdata     = '0;
        for (int i = 0; i < max_wait; i++) begin
            @(negedge clk);
            waited++;
            if (mem_ready) begin
                rdata = mem_rdata;
                break;
            end
        end
        if (!mem_ready) begin
            checks++;
            errors++;
            $display("FAIL bus_timeout addr=%h ready=%b after %0d cycles, required a ready pulse", addr, mem_ready, waited);
        end
        mem_valid = 1'b0;
        mem_wstrb = 4'h0;
    endtask

    task automatic bus_wr(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] strb);
        logic [31:0] rd;
        int          w;
        bus_xfer(addr, wdata, strb, 50, rd, w);
    endtask

    task automatic bus_rd(input logic [31:0] addr, output logic [31:0] rd);
        int w;
        bus_xfer(addr, 32'h0, 4'h0, 50, rd, w);
    endtask

    // Polls for the start bit; the returned count is the number of negedges waited.
    task automatic wait_start(input int max_wait, output int n);
        n = 0;
        for (int i = 0; i < max_wait; i++) begin
            @(negedge clk);
            n++;
            if (uart_txd == 1'b0) break;
        end
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        rst       = 1'b1;
        mem_valid = 1'b1;
        mem_addr  = A_STAT;
        mem_wdata = '0;
        mem_wstrb = 4'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (uart_txd !== 1'b1 || mem_ready !== 1'b0 || mem_rdata !== 32'h0) begin
                errors++;
                $display("FAIL reset_outputs txd=%b ready=%b rdata=%h, required 1/0/0", uart_txd, mem_ready, mem_rdata);
            end
        end
        mem_valid = 1'b0;
        rst       = 1'b0;
        @(negedge clk);
        bus_rd(A_STAT, rd);
        checks++;
        if (rd !== ST_IDLE) begin
            errors++;
            $display("FAIL reset_status got %h, required %h", rd, ST_IDLE);
        end
        bus_rd(A_DIV, rd);
        checks++;
        if (rd !== 32'd867) begin
            errors++;
            $display("FAIL reset_div got %h, required %h", rd, 32'd867);
        end
        bus_rd(A_DATA, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL data_read got %h, required 0", rd);
        end
    endtask

    task automatic check_frame(input string name, input logic [7:0] d, input int bt);
        logic [NB-1:0] exp;
        logic          ok;
        exp = frame_bits(d);
        for (int b = 0; b < NB; b++) begin
            ok = 1'b1;
            for (int c = 0; c < bt; c++) begin
                if (b > 0 || c > 0) @(negedge clk);
                if (uart_txd !== exp[b]) ok = 1'b0;
            end
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL %s bit %0d txd=%b, required %b for %0d clocks", name, b, uart_txd, exp[b], bt);
            end
        end
    endtask

    task automatic test_frame_a5();
        logic [31:0] rd;
        int          n;
        bus_wr(A_DIV, 32'd3, 4'hF);
        bus_wr(A_DATA, 32'h0000_00A5, 4'h1);
        wait_start(10, n);
        checks++;
        if (n !== 1) begin
            errors++;
            $display("FAIL a5_start_latency start seen after %0d negedges, required 1", n);
        end
        check_frame("a5_frame", 8'hA5, 4);
        @(negedge clk);
        bus_rd(A_STAT, rd);
        checks++;
        if (rd !== ST_IDLE) begin
            errors++;
            $display("FAIL a5_status_after got %h, required %h", rd, ST_IDLE);
        end
    endtask

    task automatic test_regs();
        logic [31:0] rd;
        int          pulses;
        int          hold;
        bus_wr(A_DIV, 32'h0000_1200, 4'b0010);
        bus_rd(A_DIV, rd);
        checks++;
        if (rd !== 32'h0000_1203) begin
            errors++;
            $display("FAIL div_byte_write got %h, required 00001203", rd);
        end
        // Keep mem_valid up one cycle past the pulse to expose a double accept.
        mem_addr  = A_RSV;
        mem_wstrb = 4'h0;
        mem_valid = 1'b1;
        pulses    = 0;
        hold      = 0;
        rd        = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (mem_ready) begin
                pulses++;
                rd = rd | mem_rdata;
            end
            if (pulses > 0) hold++;
            if (hold == 2) mem_valid = 1'b0;
        end
        mem_valid = 1'b0;
        checks++;
        if (pulses !== 1 || rd !== 32'h0) begin
            errors++;
            $display("FAIL ofs3_read pulses=%0d rdata=%h, required 1 pulse and 0", pulses, rd);
        end
        bus_wr(A_STAT, 32'hFFFF_FFFF, 4'hF);
        bus_wr(A_RSV, 32'hFFFF_FFFF, 4'hF);
        bus_wr(A_DATA, 32'h0000_5500, 4'b0010);
        bus_rd(A_STAT, rd);
        checks++;
        if (rd !== ST_IDLE) begin
            errors++;
            $display("FAIL ignored_writes status=%h, required %h", rd, ST_IDLE);
        end
        bus_rd(A_RSV, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL ofs3_after_write got %h, required 0", rd);
        end
    endtask

    task automatic test_back_to_back();
        logic          q[$];
        logic [31:0]   rd;
        logic [NB-1:0] got;
        logic [NB-1:0] exp;
        int            w16;
        int            w17;
        int            f;
        int            base;
        logic          tail_ok;
        bus_wr(A_DIV, 32'd20, 4'hF);
        fork
            begin
                for (int i = 0; i < 470; i++) begin
                    @(negedge clk);
                    q.push_back(uart_txd);
                end
            end
            begin
                // The 0x5A frame runs at DIV=20 and keeps the FSM busy while the FIFO fills.
                bus_wr(A_DATA, 32'h0000_005A, 4'h1);
                bus_wr(A_DIV, 32'd0, 4'hF);
                for (int j = 0; j < 16; j++) bus_xfer(A_DATA, j, 4'h1, 50, rd, w16);
                bus_xfer(A_DATA, 32'h10, 4'h1, 400, rd, w17);
            end
        join
        checks++;
        if (w16 > 2) begin
            errors++;
            $display("FAIL b2b_no_stall 16th write waited %0d cycles, required <= 2", w16);
        end
        checks++;
        if (w17 < 100) begin
            errors++;
            $display("FAIL b2b_stall 17th write waited %0d cycles, required >= 100", w17);
        end
        f = -1;
        for (int i = 0; i < 20; i++) begin
            if (f < 0 && q[i] == 1'b0) f = i;
        end
        checks++;
        if (f < 0) begin
            errors++;
            $display("FAIL b2b_first_start none within 20 cycles, required a start bit");
        end else begin
            exp = frame_bits(8'h5A);
            for (int k = 0; k < NB; k++) got[k] = q[f + k * 21 + 10];
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL b2b_slow_frame got %b, required %b", got, exp);
            end
            for (int j = 0; j < 17; j++) begin
                base = f + NB * 21 + NB * j;
                exp  = frame_bits(j[7:0]);
                for (int k = 0; k < NB; k++) got[k] = q[base + k];
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL b2b_frame_%0d got %b, required %b", j, got, exp);
                end
            end
            tail_ok = 1'b1;
            base    = f + NB * 21 + NB * 17;
            for (int i = base; i < base + 10; i++) if (q[i] !== 1'b1) tail_ok = 1'b0;
            checks++;
            if (!tail_ok) begin
                errors++;
                $display("FAIL b2b_tail txd=0 after last frame, required idle 1");
            end
        end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        logic [31:0] rd;
        int          n;
        bus_wr(A_DIV, 32'd1, 4'hF);
        bus_wr(A_DATA, 32'h0000_0007, 4'h1);
        wait_start(10, n);
        check_frame("parity_frame", 8'h07, 2);
        @(negedge clk);
        bus_rd(A_STAT, rd);
        checks++;
        if (rd !== 32'h0000_000C) begin
            errors++;
            $display("FAIL parity_status got %h, required 0000000c", rd);
        end
    endtask
`endif

    task automatic test_reset_mid_frame();
        logic [31:0] rd;
        int          n;
        int          w;
        int          elapsed;
        logic        quiet;
        bus_wr(A_DIV, 32'd3, 4'hF);
        bus_wr(A_DATA, 32'h0, 4'h1);
        wait_start(10, n);
        elapsed = 0;
        for (int j = 0; j < 5; j++) begin
            bus_xfer(A_DATA, 32'h0, 4'h1, 50, rd, w);
            elapsed += w;
        end
        // Start cycle is 0; data bit 4 of 0x00 occupies cycles 20..23.
        for (int i = elapsed; i < 21; i++) @(negedge clk);
        checks++;
        if (uart_txd !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_pre txd=%b in data bit 4, required 0", uart_txd);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (uart_txd !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_txd txd=%b after reset edge, required 1", uart_txd);
        end
        @(negedge clk);
        rst = 1'b0;
        bus_rd(A_STAT, rd);
        checks++;
        if (rd !== ST_IDLE) begin
            errors++;
            $display("FAIL rst_mid_status got %h, required %h", rd, ST_IDLE);
        end
        quiet = 1'b1;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (uart_txd !== 1'b1) quiet = 1'b0;
        end
        checks++;
        if (!quiet) begin
            errors++;
            $display("FAIL rst_mid_quiet txd went low after reset, required idle 1");
        end
    endtask

    initial begin
        rst       = 1'b1;
        mem_valid = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        @(negedge clk);
        test_reset();
        test_frame_a5();
        test_regs();
        test_back_to_back();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_periph.md
Name: uart_tx_periph

Overview:
Memory-mapped UART transmitter that sits on the picorv32 native memory bus, downstream of the core, alongside the main memory. It replaces the simulation-only console write at 0x2000_0000 with real serial output. Firmware writes bytes into a TX FIFO, and a frame FSM serialises them 8N1 on `uart_txd`. It also exposes status and baud-divisor registers.

Parameters:
BASE_ADDR, 32'h2000_0000, base of the 16-byte register window; bits [3:0] must be 0.
FIFO_DEPTH, 16, TX FIFO entries; power of 2, minimum 2.
DIV_RESET, 16'd867, reset value of DIV (100 MHz / 115200 − 1).

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
mem_valid  in  1  core request valid
mem_ready  out  1  transfer complete; high only for this block's window
mem_addr  in  32  byte address
mem_wdata  in  32  write data
mem_wstrb  in  4  byte strobes; 0 = read
mem_rdata  out  32  read data; 0 when mem_ready is low
uart_txd  out  1  serial output; idles high

Behaviour:
- Clocking/reset: single clock `clk`; reset `rst` is synchronous and active-high.
- Select: `sel = mem_valid && mem_addr[31:4] == BASE_ADDR[31:4]`. Offset is `mem_addr[3:2]`.
- Integration: the integrator ORs `mem_ready` and `mem_rdata` with the other slaves.
- Handshake timing: `mem_ready` is registered and is a one-cycle pulse, no earlier than 1 cycle after `sel`.
  - The cycle after a `mem_ready` pulse, `mem_ready` is always 0. This prevents a double accept while the core drops `mem_valid`.
- Offset 0, DATA:
  - Write with `wstrb[0]=1` pushes `wdata[7:0]`.
  - If the FIFO is full, `mem_ready` is held low (stall) until a slot frees. The push and the ready pulse then occur together.
  - Read returns 0.
- Offset 1, STATUS (read-only; writes are acked and ignored):
  - bit0 = fifo_full.
  - bit1 = busy (FSM != IDLE or FIFO not empty).
  - bit2 = fifo_empty.
  - bits[31:3] = 0.
- Offset 2, DIV:
  - Write updates `DIV[7:0]` if `wstrb[0]` and `DIV[15:8]` if `wstrb[1]`.
  - Read returns `{16'b0, DIV}`.
- Offset 3: acked, reads 0, writes ignored.
- Reset values: `mem_ready=0`, `mem_rdata=0`, `uart_txd=1`, FIFO empty, FSM=IDLE, `DIV=DIV_RESET`.
- FIFO: synchronous, with read/write pointers of width `$clog2(FIFO_DEPTH)+1`.
  - full = MSBs differ and lower bits equal; empty = pointers equal.
  - Pointers wrap naturally.
  - Full/empty flags are derived from the registered pointers. A push while full that coincides with a pop is not accepted that cycle; it is accepted on the next.
- TX FSM states: IDLE → START → DATA → STOP → IDLE.
  - IDLE: `txd=1`. If FIFO not empty, pop into the shift register, latch DIV into `bit_div`, and go to START next cycle.
  - START: `txd=0`.
  - DATA: 8 bits, LSB first.
  - STOP: `txd=1`. At the end of STOP, if FIFO not empty, go directly to START with no idle gap (the pop happens at that boundary).
  - Bit time is `bit_div+1` clocks; `DIV=0` gives 1 clock per bit.
  - Frame length is `10*(bit_div+1)` clocks.
  - A DIV write mid-frame takes effect from the next frame.
- Reset mid-frame: at the next edge `txd=1`, FIFO flushed, FSM=IDLE, and any stalled write is dropped.

Optional Feature:
- Macro: `UART_TX_PARITY_EN`.
- Defined: a PARITY state is inserted between DATA and STOP carrying even parity (XOR of the 8 data bits). Frame is 11 bits; STATUS bit3 reads 1, indicating parity is present.
- Undefined: 8N1, 10-bit frame, STATUS bit3 = 0. No parity logic is present.

Decomposition:
- Package `uart_pkg`: register offset constants (`UART_OFS_DATA=2'd0`, `STATUS=2'd1`, `DIV=2'd2`), STATUS bit positions, and the `tx_state_t` enum (IDLE, START, DATA, PARITY, STOP).
- Sub-module `uart_fifo`: parameterised sync FIFO with push/pop/full/empty/dout ports. It is reusable for a future RX block.

Test Plan:
- Reset with `DIV=DIV_RESET`, read STATUS → `mem_rdata=32'h4` (empty, not busy); `uart_txd=1` throughout reset.
- Write `DIV=3`, then write DATA `8'hA5` → `txd` shows 0, then 1,0,1,0,0,1,0,1 (LSB first), then 1; each bit 4 clocks; frame 40 clocks; STATUS then reads 4.
- `DIV=0`, 17 back-to-back DATA writes of `0x00`..`0x10` with the FSM busy → 17th write stalls (`mem_ready` low) until the first pop, then acks; all 17 bytes are emitted in order with no gaps between frames.
- Single write `wstrb=4'b0010`, `wdata=32'h0000_1200`, to DIV → DIV reads `16'h1203` (low byte unchanged from 3); offset 3 read → 0 with exactly one `mem_ready` pulse.
- Assert `rst` during DATA bit 4 of a frame with 5 bytes queued → next edge `txd=1`, STATUS=4, no further frames emitted.
- With `UART_TX_PARITY_EN`, `DIV=1`, send `8'h07` → parity bit 1, frame 22 clocks, STATUS bit3=1.
